// File: rtl/cdb_broadcaster.sv
// Common Data Bus broadcaster: per-FU completion FIFOs, round-robin arbiter, one registered broadcast per cycle.
// Accept-to-broadcast latency is one edge; fu_ready drops while a FIFO is full. CDB_BYPASS_EN adds empty-FIFO bypass.
module cdb_broadcaster #(
  parameter int NUM_FU   = 4,
  parameter int FU_DEPTH = 2,
  parameter int TAG_W    = 3,
  parameter int XLEN     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_value,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_rob_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic [$clog2(NUM_FU)-1:0]   cdb_fu_id
);

  localparam int PTR_W = $clog2(FU_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ID_W  = $clog2(NUM_FU);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(FU_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_FU - 1);

  logic [TAG_W-1:0] tag_mem_q [NUM_FU][FU_DEPTH];
  logic [XLEN-1:0]  val_mem_q [NUM_FU][FU_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q  [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_q  [NUM_FU];
  logic [CNT_W-1:0] count_q   [NUM_FU];

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_val_q, cdb_val_d;
  logic [ID_W-1:0]  cdb_id_q, cdb_id_d;

  logic [NUM_FU-1:0] req, byp_req, push, pop;
  logic              found, win_byp;
  logic [ID_W-1:0]   win;
  logic [TAG_W-1:0]  win_tag;
  logic [XLEN-1:0]   win_val;
  int                arb_idx;

  always_comb begin
    fu_ready = '0;
    req      = '0;
    byp_req  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count_q[i] != FULL);
      req[i]      = (count_q[i] != '0);
`ifdef CDB_BYPASS_EN
      byp_req[i]  = (count_q[i] == '0) && fu_valid[i];
`endif
    end
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_FU) arb_idx = arb_idx - NUM_FU;
      if (!found && (req[arb_idx] || byp_req[arb_idx])) begin
        found = 1'b1;
        win   = arb_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    // A winner with an empty FIFO can only be a bypass; the FIFO head always wins otherwise.
    win_byp = found && !req[win];
    win_tag = tag_mem_q[win][rd_ptr_q[win]];
    win_val = val_mem_q[win][rd_ptr_q[win]];
    if (win_byp) begin
      win_tag = fu_rob_tag[int'(win)*TAG_W +: TAG_W];
      win_val = fu_value[int'(win)*XLEN +: XLEN];
    end

    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = fu_valid[i] && fu_ready[i] && !squash && !(win_byp && (win == ID_W'(i)));
      pop[i]  = found && !win_byp && (win == ID_W'(i)) && !squash;
    end

    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_val_d   = cdb_val_q;
    cdb_id_d    = cdb_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (found && !squash) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_tag;
      cdb_val_d   = win_val;
      cdb_id_d    = win;
      rr_ptr_d    = (win == LAST_ID) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      cdb_id_q    <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_val_q   <= cdb_val_d;
      cdb_id_q    <= cdb_id_d;
      for (int i = 0; i < NUM_FU; i++) begin
        if (squash) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
          count_q[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
          else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]] <= fu_rob_tag[i*TAG_W +: TAG_W];
        val_mem_q[i][wr_ptr_q[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_tag = cdb_tag_q;
  assign cdb_value   = cdb_val_q;
  assign cdb_fu_id   = cdb_id_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster (default build): cycle table for arbitration order plus per-FU scoreboard.
module tb_cdb_broadcaster;

  logic         clock = 1'b0;
  logic         reset;
  logic         squash;
  logic [3:0]   fu_valid;
  logic [11:0]  fu_rob_tag;
  logic [127:0] fu_value;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [2:0]   cdb_rob_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_fu_id;

  always #5 clock = ~clock;

  cdb_broadcaster #(.NUM_FU(4), .FU_DEPTH(2), .TAG_W(3), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_rob_tag(fu_rob_tag), .fu_value(fu_value), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value), .cdb_fu_id(cdb_fu_id)
  );

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [3:0]  vld;
    logic [11:0] tags;
    logic        exp_vld;
    logic [1:0]  exp_id;
    logic [2:0]  exp_tag;
    logic [3:0]  exp_rdy;
  } vec_t;

  ent_t exp_q [4][$];
  vec_t tbl [14];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int t3, input int t2, input int t1, input int t0);
    return {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
  endfunction

  function automatic logic [127:0] vals_of(input logic [11:0] tags);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      v[i*32 +: 32] = 32'hA500_0000 | (32'(i) << 8) | {29'b0, tags[i*3 +: 3]};
    return v;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  // Called 1ns after a rising edge; returns 1ns after the next one.
  task automatic cyc(input logic [3:0] vld, input logic [11:0] tags, input logic [127:0] vals,
                     input logic sq);
    logic [3:0] rdy;
    ent_t e;
    fu_valid   = vld;
    fu_rob_tag = tags;
    fu_value   = vals;
    squash     = sq;
    #3;
    rdy = fu_ready;
    @(posedge clock);
    if (sq) clear_sb();
    else begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i] && rdy[i]) begin
          e.tag = tags[i*3 +: 3];
          e.val = vals[i*32 +: 32];
          exp_q[i].push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(4'b0, 12'b0, 128'b0, 1'b0);
  endtask

  task automatic push_all(input logic [3:0] vld, input logic [11:0] tags);
    cyc(vld, tags, vals_of(tags), 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() != 0 && n < 40) begin
      idle();
      n++;
    end
    idle();
    chk(name, 64'(pending()), 64'd0);
  endtask

  initial begin
    int nxt;
    int k;
    reset      = 1'b0;
    squash     = 1'b0;
    fu_valid   = '0;
    fu_rob_tag = '0;
    fu_value   = '0;

    fork
      begin
        #50000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clock);
        if (reset === 1'b1 && cdb_valid === 1'b1) begin
          if (exp_q[cdb_fu_id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got fu %0d tag %0h expected no broadcast", cdb_fu_id, cdb_rob_tag);
          end else begin
            ent_t e;
            e = exp_q[cdb_fu_id].pop_front();
            chk("sb_tag", 64'(cdb_rob_tag), 64'(e.tag));
            chk("sb_value", 64'(cdb_value), 64'(e.val));
          end
        end
      end
    join_none

    // rows 0-1 move rr_ptr to 2; row 2 pushes all four; rows 8-12 confirm rr_ptr ended at 2.
    tbl[0]  = '{4'b0010, pk(0,0,5,0), 1'b0, 2'd0, 3'd0, 4'b1111};
    tbl[1]  = '{4'b0000, 12'b0,       1'b1, 2'd1, 3'd5, 4'b1111};
    tbl[2]  = '{4'b1111, pk(3,2,1,0), 1'b0, 2'd0, 3'd0, 4'b1111};
    tbl[3]  = '{4'b0000, 12'b0,       1'b1, 2'd2, 3'd2, 4'b1111};
    tbl[4]  = '{4'b0000, 12'b0,       1'b1, 2'd3, 3'd3, 4'b1111};
    tbl[5]  = '{4'b0000, 12'b0,       1'b1, 2'd0, 3'd0, 4'b1111};
    tbl[6]  = '{4'b0000, 12'b0,       1'b1, 2'd1, 3'd1, 4'b1111};
    tbl[7]  = '{4'b0000, 12'b0,       1'b0, 2'd0, 3'd0, 4'b1111};
    tbl[8]  = '{4'b1111, pk(7,6,5,4), 1'b0, 2'd0, 3'd0, 4'b1111};
    tbl[9]  = '{4'b0000, 12'b0,       1'b1, 2'd2, 3'd6, 4'b1111};
    tbl[10] = '{4'b0000, 12'b0,       1'b1, 2'd3, 3'd7, 4'b1111};
    tbl[11] = '{4'b0000, 12'b0,       1'b1, 2'd0, 3'd4, 4'b1111};
    tbl[12] = '{4'b0000, 12'b0,       1'b1, 2'd1, 3'd5, 4'b1111};
    tbl[13] = '{4'b0000, 12'b0,       1'b0, 2'd0, 3'd0, 4'b1111};

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_rob_tag), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_fu_id", 64'(cdb_fu_id), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'hF);

    // Single push from FU0: not visible after its accept edge, visible after the next.
    cyc(4'b0001, pk(0,0,0,3), {96'b0, 32'hDEAD_BEEF}, 1'b0);
    chk("single_lat0_valid", 64'(cdb_valid), 64'd0);
    idle();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_rob_tag), 64'd3);
    chk("single_value", 64'(cdb_value), 64'hDEAD_BEEF);
    chk("single_fu_id", 64'(cdb_fu_id), 64'd0);

    for (int r = 0; r < 14; r++) begin
      push_all(tbl[r].vld, tbl[r].tags);
      chk($sformatf("tbl%0d_valid", r), 64'(cdb_valid), 64'(tbl[r].exp_vld));
      chk($sformatf("tbl%0d_ready", r), 64'(fu_ready), 64'(tbl[r].exp_rdy));
      if (tbl[r].exp_vld) begin
        chk($sformatf("tbl%0d_fu_id", r), 64'(cdb_fu_id), 64'(tbl[r].exp_id));
        chk($sformatf("tbl%0d_tag", r), 64'(cdb_rob_tag), 64'(tbl[r].exp_tag));
      end
    end

    // All FUs push every cycle; FU1 fills after two accepts while others win arbitration.
    for (int c = 0; c < 8; c++) begin
      push_all(4'b1111, pk(c, c, c, c));
      if (c == 0) chk("bp_rdy1_first", 64'(fu_ready[1]), 64'd1);
      if (c == 1) begin
        chk("bp_rdy1_full", 64'(fu_ready[1]), 64'd0);
        chk("bp_rdy2_popped", 64'(fu_ready[2]), 64'd1);
      end
    end
    drain("bp_drain");

    // FU2 alone, tags 0..5, pushes interleaved with pops so pointers wrap every 2 entries.
    nxt = 0;
    k   = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6 && (c % 3) != 2) begin
        push_all(4'b0100, pk(0, k, 0, 0));
        k++;
      end else idle();
      if (cdb_valid) begin
        chk("wrap_order", 64'(cdb_rob_tag), 64'(nxt));
        chk("wrap_fu_id", 64'(cdb_fu_id), 64'd2);
        nxt++;
      end
    end
    chk("wrap_count", 64'(nxt), 64'd6);
    drain("wrap_drain");

    // Squash with 5 buffered entries and fu_valid high.
    push_all(4'b1111, pk(3, 2, 1, 0));
    push_all(4'b0011, pk(0, 0, 5, 4));
    cyc(4'b1111, pk(7, 7, 7, 7), vals_of(pk(7, 7, 7, 7)), 1'b1);
    squash = 1'b0;
    chk("sq_valid", 64'(cdb_valid), 64'd0);
    chk("sq_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      idle();
      chk($sformatf("sq_quiet%0d", c), 64'(cdb_valid), 64'd0);
    end

    // Asynchronous reset with 3 entries buffered.
    push_all(4'b1111, pk(1, 2, 3, 4));
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_valid", 64'(cdb_valid), 64'd0);
    chk("mrst_ready", 64'(fu_ready), 64'hF);
    chk("mrst_value", 64'(cdb_value), 64'd0);
    clear_sb();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      idle();
      chk($sformatf("mrst_quiet%0d", c), 64'(cdb_valid), 64'd0);
    end
    push_all(4'b1000, pk(6, 0, 0, 0));
    idle();
    chk("mrst_new_valid", 64'(cdb_valid), 64'd1);
    chk("mrst_new_fu_id", 64'(cdb_fu_id), 64'd3);
    chk("mrst_new_tag", 64'(cdb_rob_tag), 64'd6);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Common Data Bus broadcaster. It collects completed results from the functional units, buffers them per unit, and arbitrates round-robin. It drives one registered broadcast per cycle (ROB tag plus value) to the ROB's `cdb_rob_packet` input and to the reservation stations. It is the producer end of the CDB→ROB completion path.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional-unit completion ports.
- `FU_DEPTH`, 2: per-FU completion FIFO depth; power of two, ≥2.
- `TAG_W`, `$clog2(ROB_SZ)` (3 for ROB_SZ=8): ROB tag width.
- `XLEN`, 32: result value width.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `squash`  in  1  synchronous flush on branch mispredict.
- `fu_valid`  in  NUM_FU  FU i presents a completed result.
- `fu_rob_tag`  in  NUM_FU×TAG_W  ROB tag of FU i's result.
- `fu_value`  in  NUM_FU×XLEN  result value of FU i.
- `fu_ready`  out  NUM_FU  FIFO i can accept this cycle.
- `cdb_valid`  out  1  broadcast valid (registered).
- `cdb_rob_tag`  out  TAG_W  broadcast ROB tag (registered).
- `cdb_value`  out  XLEN  broadcast value (registered).
- `cdb_fu_id`  out  $clog2(NUM_FU)  index of the winning FU (registered).

## Operation
- Reset values: all FIFO counts and pointers are 0; `rr_ptr`=0; `cdb_valid`=0; `cdb_rob_tag`=0; `cdb_value`=0; `cdb_fu_id`=0. `fu_ready` is all-ones once reset releases.
- Push: a result is accepted on any edge where `fu_valid[i] && fu_ready[i]`. The entry is written at `wr_ptr[i]`, `wr_ptr` wraps mod FU_DEPTH, and `count[i]` increments.
- `fu_ready[i] = (count[i] != FU_DEPTH)`, derived from the current count only. A full FIFO that pops this cycle still deasserts ready; there is no same-cycle refill.
- Arbitration: requesters are the FIFOs with `count[i] != 0`. The winner is the first requester found scanning from `rr_ptr` upward, wrapping mod NUM_FU.
- On the edge with a winner w:
  - Head of FIFO w is loaded into the cdb_* registers.
  - `cdb_valid`=1, `cdb_fu_id`=w.
  - FIFO w is popped: `rd_ptr` wraps and `count` decrements.
  - `rr_ptr` becomes (w+1) mod NUM_FU.
- With no requester: `cdb_valid`=0 next cycle, tag/value/fu_id hold their previous values, and `rr_ptr` holds.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- `squash`: on the next edge all counts and pointers are cleared, `cdb_valid`=0, and `rr_ptr` holds. Pushes presented in the squash cycle are dropped. Squash has priority over push, pop and bypass.
- Order: results from a single FU broadcast in acceptance order. No ordering is guaranteed across FUs.

## Timing
- Latency without bypass: a result accepted at edge N is broadcast no earlier than edge N+1, visible during cycle N+1→N+2.
- Throughput: one broadcast per cycle; each FU sustains one push per cycle while it is not full.
- Fairness: a FIFO that is continuously non-empty waits at most NUM_FU−1 broadcasts.
- Reset asserted mid-operation clears everything immediately and asynchronously. In-flight results are lost and the upstream pipeline is flushed by the same reset.
- The cdb_* outputs are register outputs only, with no combinational path from any input.

## Configuration
- `CDB_BYPASS_EN` defined:
  - An FU with an empty FIFO and `fu_valid` high also counts as a requester.
  - If it wins, its input is loaded directly into the cdb_* registers on the same edge and is not written to the FIFO.
  - Latency becomes accept edge N → broadcast visible after edge N. The FIFO head, when present, always takes precedence over bypass for that FU.
- `CDB_BYPASS_EN` undefined: all results pass through the FIFO, with the latency given above.

## Test plan
- Reset low mid-traffic with 3 entries buffered, then release → cdb_valid=0, fu_ready=4'b1111, and the first broadcast after release comes only from new pushes.
- FU0 pushes tag 3/value 0xDEAD_BEEF alone at edge N → cdb_valid=1, tag=3, value=0xDEADBEEF, fu_id=0 after edge N+1 (after edge N with CDB_BYPASS_EN).
- All 4 FUs push in the same cycle with rr_ptr=2 → broadcasts in FU order 2,3,0,1 on four consecutive cycles, and rr_ptr ends at 2.
- FU1 pushes every cycle while losing arbitration → fu_ready[1]=0 after 2 accepted entries. The entries are later broadcast in push order with no loss or duplication.
- Squash with FIFOs holding 5 entries total and fu_valid high → cdb_valid=0 next cycle, every count is 0, and the squash-cycle pushes are never broadcast.
- FIFO wrap: FU2 pushes 6 results in tag order 0–5, interleaved with pops → broadcasts in tag order 0–5, with pointer wrap-around every 2 entries.
